// File: rtl/imm_decode_stage_if.sv
// Handshake and result bus of the immediate-decode stage.
// The slave modport is the stage's view; the master modport drives it from both ends.
interface imm_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_instr;
    logic [XLEN-1:0]  i_pc;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [31:0]      o_instr;
    logic [XLEN-1:0]  o_pc;
    logic [XLEN-1:0]  o_imm;
    logic [2:0]       o_fmt;
    logic             o_illegal;
    logic [CNT_W-1:0] o_illegal_cnt;

    modport slave (
        input  i_valid, i_instr, i_pc, i_flush, i_ready,
        output o_ready, o_valid, o_instr, o_pc, o_imm, o_fmt, o_illegal, o_illegal_cnt
    );

    modport master (
        output i_valid, i_instr, i_pc, i_flush, i_ready,
        input  o_ready, o_valid, o_instr, o_pc, o_imm, o_fmt, o_illegal, o_illegal_cnt
    );
endinterface

// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: output register plus one skid entry, with a
// saturating count of accepted illegal instructions.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    imm_decode_stage_if.slave  bus
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    entry_t           dec;
    entry_t           out_q;
    entry_t           skid_q;
    logic             out_valid;
    logic             skid_valid;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      imm32;
    logic [31:0]      ins;
    logic             ready;
    logic             accept;
    logic             consume;

    assign ins     = bus.i_instr;
    assign ready   = !skid_valid && !i_rst;
    assign accept  = bus.i_valid && ready && !bus.i_flush;
    assign consume = out_valid && bus.i_ready;

    always_comb begin
        imm32       = 32'h0;
        dec         = '0;
        dec.instr   = ins;
        dec.pc      = bus.i_pc;
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                imm32       = {{20{ins[31]}}, ins[31:20]};
                dec.fmt     = FMT_I;
                dec.illegal = 1'b0;
            end
            7'b0100011: begin
                imm32       = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                dec.fmt     = FMT_S;
                dec.illegal = 1'b0;
            end
            7'b1100011: begin
                imm32       = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                dec.fmt     = FMT_B;
                dec.illegal = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                imm32       = {ins[31:12], 12'h000};
                dec.fmt     = FMT_U;
                dec.illegal = 1'b0;
            end
            7'b1101111: begin
                imm32       = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                dec.fmt     = FMT_J;
                dec.illegal = 1'b0;
            end
            7'b0110011: begin
                dec.fmt     = FMT_R;
                dec.illegal = 1'b0;
            end
            default: ;
        endcase
        // Sign-extend the 32-bit immediate to the datapath width.
        dec.imm        = {XLEN{imm32[31]}};
        dec.imm[31:0]  = imm32;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
        end else begin
            if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (bus.i_flush) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!out_valid || consume) begin
                // A full skid entry implies o_ready=0, so no accept can collide with it here.
                if (skid_valid) begin
                    out_q      <= skid_q;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_q     <= dec;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    // Outputs read as zero for the whole reset cycle, including the first one.
    assign bus.o_ready       = ready;
    assign bus.o_valid       = out_valid && !i_rst;
    assign bus.o_instr       = i_rst ? '0 : out_q.instr;
    assign bus.o_pc          = i_rst ? '0 : out_q.pc;
    assign bus.o_imm         = i_rst ? '0 : out_q.imm;
    assign bus.o_fmt         = i_rst ? '0 : out_q.fmt;
    assign bus.o_illegal     = i_rst ? 1'b0 : out_q.illegal;
    assign bus.o_illegal_cnt = i_rst ? '0 : cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: 32-bit instance under full traffic,
// 64-bit instance for wide sign extension.
module tb_imm_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32), .CNT_W(8)) b32 ();
    imm_decode_stage_if #(.XLEN(64), .CNT_W(8)) b64 ();

    imm_decode_stage #(.XLEN(32), .CNT_W(8)) dut32 (.i_clk(clk), .i_rst(rst), .bus(b32));
    imm_decode_stage #(.XLEN(64), .CNT_W(8)) dut64 (.i_clk(clk), .i_rst(rst), .bus(b64));

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [63:0] v, input int n);
        logic signed [63:0] s;
        s = v << (64 - n);
        return s >>> (64 - n);
    endfunction

    function automatic void model(input logic [31:0] ins, output logic [63:0] imm,
                                  output logic [2:0] fmt, output logic ill);
        logic [63:0] v;
        v   = 64'(ins);
        imm = 64'h0;
        fmt = 3'd7;
        ill = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin imm = sext(v >> 20, 12); fmt = 3'd1; end
            7'h23: begin imm = sext(((v >> 25) << 5) | ((v >> 7) & 31), 12); fmt = 3'd2; end
            7'h63: begin
                imm = sext((((v >> 31) & 1) << 12) | (((v >> 7) & 1) << 11) |
                           (((v >> 25) & 63) << 5) | (((v >> 8) & 15) << 1), 13);
                fmt = 3'd3;
            end
            7'h37, 7'h17: begin imm = sext(v & 64'hFFFF_F000, 32); fmt = 3'd4; end
            7'h6F: begin
                imm = sext((((v >> 31) & 1) << 20) | (((v >> 12) & 255) << 12) |
                           (((v >> 20) & 1) << 11) | (((v >> 21) & 1023) << 1), 21);
                fmt = 3'd5;
            end
            7'h33: fmt = 3'd0;
            default: ill = 1'b1;
        endcase
    endfunction

    // Reference: occupancy of the queue tracks the output and skid entries.
    always @(negedge clk) begin
        logic [63:0] mimm;
        logic [2:0]  mfmt;
        logic        mill;
        logic        mready;
        exp_t        e;
        if (rst) begin
            chk("rst_o_valid", 64'(b32.o_valid), 64'd0);
            chk("rst_o_ready", 64'(b32.o_ready), 64'd0);
            chk("rst_cnt", 64'(b32.o_illegal_cnt), 64'd0);
            q.delete();
            exp_cnt = 0;
        end else begin
            chk("o_valid", 64'(b32.o_valid), 64'(q.size() != 0));
            chk("o_ready", 64'(b32.o_ready), 64'(q.size() < 2));
            chk("cnt", 64'(b32.o_illegal_cnt), 64'(exp_cnt));
            mready = (q.size() < 2);
            if (b32.i_flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && b32.i_ready) begin
                    e = q.pop_front();
                    chk("o_instr", 64'(b32.o_instr), 64'(e.instr));
                    chk("o_pc", 64'(b32.o_pc), 64'(e.pc));
                    chk("o_imm", 64'(b32.o_imm), 64'(e.imm));
                    chk("o_fmt", 64'(b32.o_fmt), 64'(e.fmt));
                    chk("o_illegal", 64'(b32.o_illegal), 64'(e.ill));
                end
                if (b32.i_valid && mready) begin
                    model(b32.i_instr, mimm, mfmt, mill);
                    e.instr = b32.i_instr;
                    e.pc    = b32.i_pc;
                    e.imm   = mimm[31:0];
                    e.fmt   = mfmt;
                    e.ill   = mill;
                    q.push_back(e);
                    if (mill && exp_cnt < 255) exp_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int acc = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!rst && b32.o_ready && !b32.i_flush) begin
                acc = 1;
                break;
            end
        end
        chk("accept_timeout", 64'(acc), 64'd1);
        @(posedge clk);
        #1;
        b32.i_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        b32.i_valid = 1'b1;
        b32.i_instr = ins;
        b32.i_pc    = pc;
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        b32.i_valid = 1'b0;
        b32.i_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    logic [6:0]  ops [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    logic [31:0] vec [3] = '{32'hFFC12083, 32'hFE000CE3, 32'h008000EF};
    logic [31:0] r;

    initial begin
        b32.i_valid = 0; b32.i_instr = 0; b32.i_pc = 0; b32.i_flush = 0; b32.i_ready = 0;
        b64.i_valid = 0; b64.i_instr = 0; b64.i_pc = 0; b64.i_flush = 0; b64.i_ready = 1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_o_instr", 64'(b32.o_instr), 64'd0);
        chk("rst_o_pc", 64'(b32.o_pc), 64'd0);
        chk("rst_o_imm", 64'(b32.o_imm), 64'd0);
        chk("rst_o_fmt", 64'(b32.o_fmt), 64'd0);
        chk("rst_o_illegal", 64'(b32.o_illegal), 64'd0);
        chk("rst64_o_valid", 64'(b64.o_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(b32.o_ready), 64'd1);
        @(posedge clk); #1;

        // Known vectors, back to back with downstream always ready.
        b32.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b32.i_valid = 1'b1;
            b32.i_instr = vec[i];
            b32.i_pc    = 32'(i * 4);
            tick();
        end
        b32.i_valid = 1'b0;
        drain();

        // Wide datapath sign extension.
        b64.i_valid = 1'b1; b64.i_instr = 32'h80000537; b64.i_pc = 64'h1000;
        tick();
        b64.i_instr = 32'h00C12423; b64.i_pc = 64'h1004;
        @(negedge clk);
        chk("w64_valid_u", 64'(b64.o_valid), 64'd1);
        chk("w64_imm_u", b64.o_imm, 64'hFFFF_FFFF_8000_0000);
        chk("w64_fmt_u", 64'(b64.o_fmt), 64'd4);
        @(posedge clk); #1;
        b64.i_valid = 1'b0;
        @(negedge clk);
        chk("w64_imm_s", b64.o_imm, 64'h8);
        chk("w64_fmt_s", 64'(b64.o_fmt), 64'd2);
        chk("w64_pc_s", b64.o_pc, 64'h1004);
        @(posedge clk); #1;

        // Stall: two entries fill, third waits, all leave in order.
        b32.i_ready = 1'b0;
        send(32'h00100093, 32'h0);
        send(32'h00200093, 32'h4);
        b32.i_valid = 1'b1; b32.i_instr = 32'h00300093; b32.i_pc = 32'h8;
        repeat (3) tick();
        b32.i_ready = 1'b1;
        wait_accept();
        drain();

        // Mixed random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            r = $urandom();
            b32.i_ready = 1'($urandom_range(0, 1));
            b32.i_valid = 1'($urandom_range(0, 1));
            b32.i_pc    = 32'(i * 4);
            if ($urandom_range(0, 9) < 8) b32.i_instr = {r[31:7], ops[$urandom_range(0, 8)]};
            else                          b32.i_instr = r;
            tick();
        end
        drain();

        // Counter saturation with all-zero words.
        for (int i = 0; i < 300; i++) send(32'h0, 32'(i));
        drain();
        @(negedge clk);
        chk("cnt_saturated", 64'(b32.o_illegal_cnt), 64'd255);
        @(posedge clk); #1;

        // Flush with both entries full and a valid input alongside.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        b32.i_ready = 1'b0;
        send(32'h00000013, 32'h100);
        send(32'hFFFFFFFF, 32'h104);
        b32.i_valid = 1'b1; b32.i_instr = 32'h0; b32.i_pc = 32'h108; b32.i_flush = 1'b1;
        tick();
        b32.i_valid = 1'b0; b32.i_flush = 1'b0;
        @(negedge clk);
        chk("flush_o_valid", 64'(b32.o_valid), 64'd0);
        chk("flush_o_ready", 64'(b32.o_ready), 64'd1);
        chk("flush_cnt", 64'(b32.o_illegal_cnt), 64'd1);
        @(posedge clk); #1;
        b32.i_ready = 1'b1;
        repeat (3) tick();

        // Reset with both entries full.
        b32.i_ready = 1'b0;
        send(32'h0, 32'h200);
        send(32'h0, 32'h204);
        b32.i_valid = 1'b1; b32.i_instr = 32'h0; b32.i_pc = 32'h208;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_o_valid", 64'(b32.o_valid), 64'd0);
        @(posedge clk); #1;
        b32.i_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_cnt", 64'(b32.o_illegal_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", 64'(b32.o_ready), 64'd1);
        @(posedge clk); #1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; legal values 32 or 64.
REQ-002 Parameter: CNT_W, 8, width of the illegal-instruction counter; legal values 1 to 32.
REQ-003 One clock; reset is synchronous and active-high. The clock port is i_clk and the reset port is i_rst.
REQ-004 i_clk  in  1  clock; all state updates on its rising edge.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_valid  in  1  upstream instruction valid.
REQ-007 o_ready  out  1  stage can accept an instruction this cycle.
REQ-008 i_instr  in  32  raw instruction word.
REQ-009 i_pc  in  XLEN  PC of i_instr.
REQ-010 i_flush  in  1  discard all held and incoming instructions.
REQ-011 o_valid  out  1  decoded result valid.
REQ-012 i_ready  in  1  downstream accepts the result.
REQ-013 o_instr  out  32  instruction word passed through.
REQ-014 o_pc  out  XLEN  PC passed through.
REQ-015 o_imm  out  XLEN  signed immediate, sign-extended from instruction bit 31.
REQ-016 o_fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal; 6 is never driven.
REQ-017 o_illegal  out  1  the held instruction is illegal.
REQ-018 o_illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-019 An instruction is accepted when i_valid=1, o_ready=1 and i_flush=0.
REQ-020 A result is consumed when o_valid=1 and i_ready=1.
REQ-021 Decode is combinational on accept. The result is registered, so latency from accept to o_valid is exactly 1 cycle.
REQ-022 The stage holds two entries: an output register and a skid register. o_ready is !skid_valid && !i_rst.
REQ-023 Accept while the output register is empty or being consumed: the new result loads the output register.
REQ-024 Accept while o_valid=1 and i_ready=0: the new result loads the skid register, and o_ready falls on the next cycle.
REQ-025 Consume while the skid register is full: the skid entry moves to the output register and o_ready rises on the next cycle.
REQ-026 Results leave in acceptance order. No entry is dropped or duplicated except by flush.
REQ-027 While o_valid=1 and i_ready=0, every output except o_ready and o_illegal_cnt holds stable.
REQ-028 Immediates by opcode[6:0]:
- I-format, from instr[31:20]: LOAD 0000011, OP-IMM 0010011, JALR 1100111.
- S-format, {instr[31:25], instr[11:7]}: STORE 0100011.
- B-format, {instr[31], instr[7], instr[30:25], instr[11:8], 0}: BRANCH 1100011.
- U-format, {instr[31:12], 12'h000}: LUI 0110111, AUIPC 0010111.
- J-format, {instr[31], instr[19:12], instr[20], instr[30:21], 0}: JAL 1101111.
- R-format: OP 0110011 gives o_imm=0 and o_fmt=0.
- All immediates are sign-extended to XLEN.
REQ-029 Any other opcode, including instr[1:0]!=11, is illegal: o_imm=0, o_fmt=7, o_illegal=1. The output is never X.
REQ-030 o_illegal_cnt increments by 1 on each accepted illegal instruction. It saturates at 2^CNT_W-1 and never wraps. Flush does not clear it.
REQ-031 i_flush=1 clears the output and skid valid bits on the next edge. The input in the flush cycle is neither accepted nor counted. o_ready=1 on the following cycle.
REQ-032 Simultaneous consume and accept with the skid register empty: the output register reloads with the new result and o_valid stays 1.

Reset
REQ-033 While i_rst=1: o_valid=0, skid_valid=0, o_ready=0, o_illegal_cnt=0, and o_instr, o_pc, o_imm, o_fmt, o_illegal are all 0.
REQ-034 Reset mid-operation discards both entries. i_rst has priority over i_flush and over any handshake. o_ready=1 on the first cycle after i_rst deasserts.

Verification
REQ-035 XLEN=32, i_ready=1: accept 0xFFC12083, then 0xFE000CE3, then 0x008000EF. The results are, each 1 cycle later:
- o_imm=0xFFFFFFFC, o_fmt=1.
- o_imm=0xFFFFFFF8, o_fmt=3.
- o_imm=0x00000008, o_fmt=5.
REQ-036 XLEN=64: accept 0x80000537 -> o_imm=0xFFFFFFFF80000000, o_fmt=4. Accept 0x00C12423 -> o_imm=0x8, o_fmt=2.
REQ-037 Hold i_ready=0 and offer PCs 0x0, 0x4, 0x8 back-to-back. 0x0 and 0x4 are accepted and o_ready=0 from the third cycle. Then raise i_ready: PCs exit in order 0x0, 0x4, 0x8 with no loss or duplication.
REQ-038 CNT_W=8: accept 300 instructions of 0x00000000 -> each has o_illegal=1, o_imm=0, o_fmt=7, and o_illegal_cnt saturates at 255.
REQ-039 With both entries full, assert i_flush for one cycle alongside a valid input. Next cycle: o_valid=0, o_ready=1, o_illegal_cnt unchanged, and the flushed input never appears.
REQ-040 Assert i_rst with both entries full -> o_valid=0 and o_illegal_cnt=0 next cycle. o_ready=1 the cycle after i_rst falls.
